// File: rtl/eth_pkg.sv
// Shared constants, state encoding and helpers for the Ethernet TX framer
// and the CRC-32 octet engine.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE_OCTET = 8'h55;
    localparam logic [7:0]  ETH_SFD            = 8'hD5;
    localparam logic [15:0] ETH_TPID_VLAN      = 16'h8100;
    localparam logic [31:0] CRC32_POLY_REFL    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT         = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE      = 32'hDEBB20E3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SFD,
        S_DST,
        S_SRC,
        S_VLAN,
        S_ETYPE,
        S_PAYLOAD,
        S_PAD,
        S_FCS,
        S_IFG
    } eth_tx_state_t;

    // Octet idx of a MAC address, idx 0 being the first octet on the wire.
    function automatic logic [7:0] mac_octet(input logic [47:0] mac, input logic [2:0] idx);
        logic [7:0] r;
        case (idx)
            3'd0:    r = mac[47:40];
            3'd1:    r = mac[39:32];
            3'd2:    r = mac[31:24];
            3'd3:    r = mac[23:16];
            3'd4:    r = mac[15:8];
            default: r = mac[7:0];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// Combinational CRC-32 (reflected 0xEDB88320) advance by one octet, LSB first.
// Shared between the TX framer and the RX FCS checker.
module eth_crc32_byte
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/eth_framer_mk2.sv
// Byte-wide AXI-Stream Ethernet TX framer: preamble, SFD, MACs, optional 802.1Q
// tag, ethertype, payload, zero pad, optional FCS, then an enforced gap.
module eth_framer_mk2
    import eth_pkg::*;
#(
    parameter int PREAMBLE_OCTETS    = 7,
    parameter int MIN_PAYLOAD_OCTETS = 46,
    parameter int PAD_EN             = 1,
    parameter int FCS_EN             = 1,
    parameter int IFG_CYCLES         = 12
) (
    input  logic          clk,
    input  logic          aresetn,
    input  logic [47:0]   src_mac,
    input  logic [47:0]   dst_mac,
    input  logic [15:0]   ethertype,
    input  logic          vlan_en,
    input  logic [15:0]   vlan_tci,
    output logic          payload_axis_tready,
    input  logic          payload_axis_tvalid,
    input  logic          payload_axis_tlast,
    input  logic [7:0]    payload_axis_tdata,
    input  logic          out_axis_tready,
    output logic          out_axis_tvalid,
    output logic          out_axis_tlast,
    output logic [7:0]    out_axis_tdata,
    output logic          frame_done,
    output eth_tx_state_t tx_state
);

    // Handshakes are AXI-Stream: a beat transfers on a clock edge where
    // tvalid && tready; a raised tvalid holds, with tdata stable, until then.

    localparam logic [7:0]  PRE_LAST  = 8'(PREAMBLE_OCTETS - 1);
    localparam logic [10:0] MIN_PLAIN = 11'(MIN_PAYLOAD_OCTETS);
    localparam logic [10:0] MIN_VLAN  = 11'(MIN_PAYLOAD_OCTETS - 4);
    localparam bit          PAD_ON    = (PAD_EN != 0);
    localparam bit          FCS_ON    = (FCS_EN != 0);
    // The IDLE cycle that samples payload_tvalid is the last clock of the gap,
    // so the IFG state itself lasts IFG_CYCLES-1 clocks.
    localparam logic [7:0]  IFG_LAST    = 8'((IFG_CYCLES > 1) ? IFG_CYCLES - 2 : 0);
    localparam eth_tx_state_t AFTER_FRAME = (IFG_CYCLES > 1) ? S_IFG : S_IDLE;

    eth_tx_state_t state, state_nxt;
    logic [7:0]    idx, idx_nxt;
    logic [10:0]   pay_cnt, pay_cnt_nxt;
    logic [31:0]   crc, crc_nxt;
    logic [7:0]    ifg_cnt, ifg_cnt_nxt;
    logic          load_hdr;

    logic [47:0]   dst_q;
    logic [47:0]   src_q;
    logic [15:0]   etype_q;
    logic          vlan_q;
    logic [15:0]   tci_q;

    logic [10:0]   pay_cnt_inc;
    logic [10:0]   min_len;
    logic          short_after;
    logic          pad_last;
    logic          beat;
    logic [31:0]   crc_calc;

    assign tx_state    = state;
    assign pay_cnt_inc = (pay_cnt == 11'h7FF) ? pay_cnt : pay_cnt + 11'd1;
    assign min_len     = vlan_q ? MIN_VLAN : MIN_PLAIN;
    assign short_after = PAD_ON && (pay_cnt_inc < min_len);
    assign pad_last    = (pay_cnt_inc >= min_len);
    assign beat        = out_axis_tvalid && out_axis_tready;
    assign frame_done  = beat && out_axis_tlast;

    eth_crc32_byte u_crc (
        .crc_in  (crc),
        .data    (out_axis_tdata),
        .crc_out (crc_calc)
    );

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= S_IDLE;
            idx     <= 8'd0;
            pay_cnt <= 11'd0;
            crc     <= CRC32_INIT;
            ifg_cnt <= 8'd0;
            dst_q   <= 48'd0;
            src_q   <= 48'd0;
            etype_q <= 16'd0;
            vlan_q  <= 1'b0;
            tci_q   <= 16'd0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            pay_cnt <= pay_cnt_nxt;
            crc     <= crc_nxt;
            ifg_cnt <= ifg_cnt_nxt;
            if (load_hdr) begin
                dst_q   <= dst_mac;
                src_q   <= src_mac;
                etype_q <= ethertype;
                vlan_q  <= vlan_en;
                tci_q   <= vlan_tci;
            end
        end
    end

    // Output octet selection; depends only on registered state, so it holds
    // steady across stalls (payload passthrough relies on upstream holding).
    always_comb begin
        out_axis_tvalid     = 1'b0;
        out_axis_tlast      = 1'b0;
        out_axis_tdata      = 8'h00;
        payload_axis_tready = 1'b0;
        case (state)
            S_PREAMBLE: begin
                out_axis_tvalid = 1'b1;
                out_axis_tdata  = ETH_PREAMBLE_OCTET;
            end
            S_SFD: begin
                out_axis_tvalid = 1'b1;
                out_axis_tdata  = ETH_SFD;
            end
            S_DST: begin
                out_axis_tvalid = 1'b1;
                out_axis_tdata  = mac_octet(dst_q, idx[2:0]);
            end
            S_SRC: begin
                out_axis_tvalid = 1'b1;
                out_axis_tdata  = mac_octet(src_q, idx[2:0]);
            end
            S_VLAN: begin
                out_axis_tvalid = 1'b1;
                case (idx[1:0])
                    2'd0:    out_axis_tdata = ETH_TPID_VLAN[15:8];
                    2'd1:    out_axis_tdata = ETH_TPID_VLAN[7:0];
                    2'd2:    out_axis_tdata = tci_q[15:8];
                    default: out_axis_tdata = tci_q[7:0];
                endcase
            end
            S_ETYPE: begin
                out_axis_tvalid = 1'b1;
                out_axis_tdata  = idx[0] ? etype_q[7:0] : etype_q[15:8];
            end
            S_PAYLOAD: begin
                out_axis_tvalid     = payload_axis_tvalid;
                out_axis_tdata      = payload_axis_tdata;
                payload_axis_tready = out_axis_tready;
                out_axis_tlast      = !FCS_ON && payload_axis_tlast && !short_after;
            end
            S_PAD: begin
                out_axis_tvalid = 1'b1;
                out_axis_tlast  = !FCS_ON && pad_last;
            end
            S_FCS: begin
                out_axis_tvalid = 1'b1;
                case (idx[1:0])
                    2'd0:    out_axis_tdata = ~crc[7:0];
                    2'd1:    out_axis_tdata = ~crc[15:8];
                    2'd2:    out_axis_tdata = ~crc[23:16];
                    default: out_axis_tdata = ~crc[31:24];
                endcase
                out_axis_tlast = (idx[1:0] == 2'd3);
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        pay_cnt_nxt = pay_cnt;
        crc_nxt     = crc;
        ifg_cnt_nxt = ifg_cnt;
        load_hdr    = 1'b0;
        case (state)
            S_IDLE: begin
                if (payload_axis_tvalid) begin
                    load_hdr    = 1'b1;
                    state_nxt   = S_PREAMBLE;
                    idx_nxt     = 8'd0;
                    pay_cnt_nxt = 11'd0;
                    crc_nxt     = CRC32_INIT;
                    ifg_cnt_nxt = 8'd0;
                end
            end
            S_PREAMBLE: begin
                if (beat) begin
                    if (idx == PRE_LAST) begin
                        state_nxt = S_SFD;
                        idx_nxt   = 8'd0;
                    end else begin
                        idx_nxt = idx + 8'd1;
                    end
                end
            end
            S_SFD: begin
                if (beat) begin
                    state_nxt = S_DST;
                    idx_nxt   = 8'd0;
                end
            end
            S_DST: begin
                if (beat) begin
                    crc_nxt = crc_calc;
                    if (idx == 8'd5) begin
                        state_nxt = S_SRC;
                        idx_nxt   = 8'd0;
                    end else begin
                        idx_nxt = idx + 8'd1;
                    end
                end
            end
            S_SRC: begin
                if (beat) begin
                    crc_nxt = crc_calc;
                    if (idx == 8'd5) begin
                        state_nxt = vlan_q ? S_VLAN : S_ETYPE;
                        idx_nxt   = 8'd0;
                    end else begin
                        idx_nxt = idx + 8'd1;
                    end
                end
            end
            S_VLAN: begin
                if (beat) begin
                    crc_nxt = crc_calc;
                    if (idx == 8'd3) begin
                        state_nxt = S_ETYPE;
                        idx_nxt   = 8'd0;
                    end else begin
                        idx_nxt = idx + 8'd1;
                    end
                end
            end
            S_ETYPE: begin
                if (beat) begin
                    crc_nxt = crc_calc;
                    if (idx == 8'd1) begin
                        state_nxt = S_PAYLOAD;
                        idx_nxt   = 8'd0;
                    end else begin
                        idx_nxt = idx + 8'd1;
                    end
                end
            end
            S_PAYLOAD: begin
                if (beat) begin
                    crc_nxt     = crc_calc;
                    pay_cnt_nxt = pay_cnt_inc;
                    if (payload_axis_tlast) begin
                        idx_nxt = 8'd0;
                        if (short_after) begin
                            state_nxt = S_PAD;
                        end else if (FCS_ON) begin
                            state_nxt = S_FCS;
                        end else begin
                            state_nxt = AFTER_FRAME;
                        end
                    end
                end
            end
            S_PAD: begin
                if (beat) begin
                    crc_nxt     = crc_calc;
                    pay_cnt_nxt = pay_cnt_inc;
                    if (pad_last) begin
                        idx_nxt   = 8'd0;
                        state_nxt = FCS_ON ? S_FCS : AFTER_FRAME;
                    end
                end
            end
            S_FCS: begin
                if (beat) begin
                    if (idx == 8'd3) begin
                        state_nxt = AFTER_FRAME;
                        idx_nxt   = 8'd0;
                    end else begin
                        idx_nxt = idx + 8'd1;
                    end
                end
            end
            S_IFG: begin
                if (ifg_cnt == IFG_LAST) begin
                    state_nxt   = S_IDLE;
                    ifg_cnt_nxt = 8'd0;
                end else begin
                    ifg_cnt_nxt = ifg_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_eth_framer_mk2.sv
// Self-checking bench for eth_framer_mk2: a frame-level reference model builds
// expected octet streams that a monitor-fed scoreboard compares against.
module tb_eth_framer_mk2;
    import eth_pkg::*;

    typedef logic [7:0] bq_t[$];

    logic          clk;
    logic          aresetn;
    logic [47:0]   src_mac;
    logic [47:0]   dst_mac;
    logic [15:0]   ethertype;
    logic          vlan_en;
    logic [15:0]   vlan_tci;
    logic          payload_axis_tready;
    logic          payload_axis_tvalid;
    logic          payload_axis_tlast;
    logic [7:0]    payload_axis_tdata;
    logic          out_axis_tready;
    logic          out_axis_tvalid;
    logic          out_axis_tlast;
    logic [7:0]    out_axis_tdata;
    logic          frame_done;
    eth_tx_state_t tx_state;

    eth_framer_mk2 #(
        .PREAMBLE_OCTETS    (7),
        .MIN_PAYLOAD_OCTETS (46),
        .PAD_EN             (1),
        .FCS_EN             (1),
        .IFG_CYCLES         (12)
    ) dut (
        .clk                 (clk),
        .aresetn             (aresetn),
        .src_mac             (src_mac),
        .dst_mac             (dst_mac),
        .ethertype           (ethertype),
        .vlan_en             (vlan_en),
        .vlan_tci            (vlan_tci),
        .payload_axis_tready (payload_axis_tready),
        .payload_axis_tvalid (payload_axis_tvalid),
        .payload_axis_tlast  (payload_axis_tlast),
        .payload_axis_tdata  (payload_axis_tdata),
        .out_axis_tready     (out_axis_tready),
        .out_axis_tvalid     (out_axis_tvalid),
        .out_axis_tlast      (out_axis_tlast),
        .out_axis_tdata      (out_axis_tdata),
        .frame_done          (frame_done),
        .tx_state            (tx_state)
    );

    // ---------------- clock / reset ----------------
    int cyc;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // ---------------- scoreboard state ----------------
    int          n_checks;
    int          n_errors;
    logic [7:0]  exp_q[$];
    logic        exp_last_q[$];
    logic [7:0]  rx_q[$];
    logic        rx_last_q[$];
    int          sof_q[$];
    int          gap_q[$];
    logic [7:0]  drv_q[$];
    logic        drv_last_q[$];
    logic [7:0]  pl_q[$];
    logic [31:0] crc_tab[256];
    int          tv_cyc;
    logic        rand_rdy;
    logic        abort;

    // monitor-owned
    int          done_cnt;
    int          done_bad;
    int          stall_err;
    int          stall_seen;
    int          frm_bytes;
    int          gap_cnt;
    logic        in_frame;
    logic        in_gap;
    logic        prev_stall;
    logic [7:0]  prev_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_raw(input bq_t q);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (q[i]) c = crc_tab[c[7:0] ^ q[i]] ^ (c >> 8);
        return c;
    endfunction

    // Reference frame: header, optional tag, payload (pl_q), pad, inverted FCS.
    task automatic model_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] et,
                               input logic v, input logic [15:0] t);
        bq_t body;
        logic [31:0] fcs;
        int min_len;
        body = {};
        for (int i = 0; i < 6; i++) body.push_back(8'(d >> (40 - 8 * i)));
        for (int i = 0; i < 6; i++) body.push_back(8'(s >> (40 - 8 * i)));
        if (v) begin
            body.push_back(8'h81);
            body.push_back(8'h00);
            body.push_back(t[15:8]);
            body.push_back(t[7:0]);
        end
        body.push_back(et[15:8]);
        body.push_back(et[7:0]);
        foreach (pl_q[i]) body.push_back(pl_q[i]);
        min_len = v ? 42 : 46;
        for (int i = pl_q.size(); i < min_len; i++) body.push_back(8'h00);
        fcs = ~crc_raw(body);
        for (int i = 0; i < 4; i++) body.push_back(8'(fcs >> (8 * i)));
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(8'h55);
            exp_last_q.push_back(1'b0);
        end
        exp_q.push_back(8'hD5);
        exp_last_q.push_back(1'b0);
        foreach (body[i]) begin
            exp_q.push_back(body[i]);
            exp_last_q.push_back(i == body.size() - 1);
        end
    endtask

    task automatic stage_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] et,
                               input logic v, input logic [15:0] t);
        model_frame(d, s, et, v, t);
        foreach (pl_q[i]) begin
            drv_q.push_back(pl_q[i]);
            drv_last_q.push_back(i == pl_q.size() - 1);
        end
    endtask

    task automatic set_hdr(input logic [47:0] d, input logic [47:0] s, input logic [15:0] et,
                           input logic v, input logic [15:0] t);
        dst_mac   = d;
        src_mac   = s;
        ethertype = et;
        vlan_en   = v;
        vlan_tci  = t;
    endtask

    task automatic rand_payload(input int n);
        pl_q = {};
        for (int i = 0; i < n; i++) pl_q.push_back(8'($urandom_range(0, 255)));
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_payload(input int gap_pct);
        int k;
        logic hs;
        for (int i = 0; i < drv_q.size(); i++) begin
            if (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
                payload_axis_tvalid = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            payload_axis_tvalid = 1'b1;
            payload_axis_tdata  = drv_q[i];
            payload_axis_tlast  = drv_last_q[i];
            if (i == 0) tv_cyc = cyc;
            hs = 1'b0;
            k  = 0;
            while (!hs) begin
                @(negedge clk);
                hs = payload_axis_tvalid && payload_axis_tready;
                @(posedge clk);
                #1;
                k++;
                if (abort) begin
                    payload_axis_tvalid = 1'b0;
                    payload_axis_tlast  = 1'b0;
                    return;
                end
                if (k > 3000) begin
                    check_eq("drv_stall", k, 0);
                    payload_axis_tvalid = 1'b0;
                    return;
                end
            end
        end
        payload_axis_tvalid = 1'b0;
        payload_axis_tlast  = 1'b0;
        payload_axis_tdata  = 8'h00;
    endtask

    task automatic run_frames(input int n, input int gap_pct);
        int db;
        db = done_cnt;
        fork
            drive_payload(gap_pct);
            begin
                for (int k = 0; k < 6000 && done_cnt < db + n; k++) @(negedge clk);
            end
        join
        check_eq("frames_done", done_cnt - db, n);
        drv_q      = {};
        drv_last_q = {};
    endtask

    task automatic compare_stream(input string tag, input int base);
        check_eq({tag, "_len"}, rx_q.size() - base, exp_q.size());
        foreach (exp_q[i]) begin
            if (base + i < rx_q.size()) begin
                check_eq({tag, "_byte"}, rx_q[base + i], exp_q[i]);
                check_eq({tag, "_last"}, rx_last_q[base + i], exp_last_q[i]);
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_tvalid"}, out_axis_tvalid, 1'b0);
        check_eq({tag, "_tlast"}, out_axis_tlast, 1'b0);
        check_eq({tag, "_tdata"}, out_axis_tdata, 8'h00);
        check_eq({tag, "_done"}, frame_done, 1'b0);
        check_eq({tag, "_ptready"}, payload_axis_tready, 1'b0);
        check_eq({tag, "_state"}, 32'(tx_state), 32'(S_IDLE));
    endtask

    // ---------------- tready driver ----------------
    initial begin
        out_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_axis_tready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // ---------------- output monitor ----------------
    initial begin
        done_cnt = 0; done_bad = 0; stall_err = 0; stall_seen = 0;
        frm_bytes = 0; gap_cnt = 0; in_frame = 0; in_gap = 0;
        prev_stall = 0; prev_data = 8'h00;
        forever begin
            @(negedge clk);
            if (!aresetn) begin
                prev_stall = 1'b0;
                in_frame   = 1'b0;
                in_gap     = 1'b0;
                frm_bytes  = 0;
            end else begin
                if (prev_stall) begin
                    stall_seen++;
                    if (!out_axis_tvalid || out_axis_tdata != prev_data) stall_err++;
                end
                prev_stall = out_axis_tvalid && !out_axis_tready;
                prev_data  = out_axis_tdata;
                if (out_axis_tvalid && !in_frame) begin
                    sof_q.push_back(cyc);
                    in_frame  = 1'b1;
                    frm_bytes = 0;
                    if (in_gap) gap_q.push_back(gap_cnt);
                    in_gap = 1'b0;
                end else if (!out_axis_tvalid && in_gap) begin
                    gap_cnt++;
                end
                if (frame_done) begin
                    done_cnt++;
                    if (!(out_axis_tvalid && out_axis_tready && out_axis_tlast)) done_bad++;
                end
                if (out_axis_tvalid && out_axis_tready) begin
                    rx_q.push_back(out_axis_tdata);
                    rx_last_q.push_back(out_axis_tlast);
                    frm_bytes++;
                    if (out_axis_tlast) begin
                        in_frame = 1'b0;
                        in_gap   = 1'b1;
                        gap_cnt  = 0;
                    end
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] c;
        int base, base2, sbase, gbase, db, mism;
        bq_t r;
        logic [47:0] d_r, s_r;
        logic [15:0] et_r;

        n_checks = 0;
        n_errors = 0;
        rand_rdy = 1'b0;
        abort    = 1'b0;
        for (int n = 0; n < 256; n++) begin
            c = 32'(n);
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[n] = c;
        end

        aresetn             = 1'b0;
        payload_axis_tvalid = 1'b0;
        payload_axis_tlast  = 1'b0;
        payload_axis_tdata  = 8'h00;
        set_hdr(48'h0, 48'h0, 16'h0, 1'b0, 16'h0);
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("rst");
        aresetn = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_rst");

        // A: 46-octet counting payload, no pad, residue check, start latency
        set_hdr(48'h020000000001, 48'h020000000002, 16'h0800, 1'b0, 16'h0);
        pl_q = {};
        for (int i = 0; i < 46; i++) pl_q.push_back(8'(i));
        exp_q = {}; exp_last_q = {};
        stage_frame(dst_mac, src_mac, ethertype, vlan_en, vlan_tci);
        base = rx_q.size(); sbase = sof_q.size();
        run_frames(1, 0);
        compare_stream("a", base);
        r = {};
        for (int i = 8; i < 72 && base + i < rx_q.size(); i++) r.push_back(rx_q[base + i]);
        check_eq("a_residue", crc_raw(r), 32'hDEBB20E3);
        if (sof_q.size() > sbase) check_eq("a_latency", sof_q[sbase] - tv_cyc, 1);
        else check_eq("a_sof_seen", sof_q.size(), sbase + 1);

        // B: one-octet payload -> 45 pad octets
        pl_q = {};
        pl_q.push_back(8'hAB);
        exp_q = {}; exp_last_q = {};
        stage_frame(dst_mac, src_mac, ethertype, vlan_en, vlan_tci);
        base = rx_q.size();
        run_frames(1, 0);
        compare_stream("b", base);

        // C: VLAN tag, 10-octet payload -> 32 pad octets
        set_hdr(48'h0A1B2C3D4E5F, 48'h665544332211, 16'h86DD, 1'b1, 16'h0064);
        rand_payload(10);
        exp_q = {}; exp_last_q = {};
        stage_frame(dst_mac, src_mac, ethertype, vlan_en, vlan_tci);
        base = rx_q.size();
        run_frames(1, 0);
        compare_stream("c", base);

        // D: 100-octet frame, first with tready=1, then with random stalls
        d_r  = {16'($urandom_range(0, 65535)), 32'($urandom)};
        s_r  = {16'($urandom_range(0, 65535)), 32'($urandom)};
        et_r = 16'($urandom_range(0, 65535));
        set_hdr(d_r, s_r, et_r, 1'b0, 16'h0);
        rand_payload(100);
        exp_q = {}; exp_last_q = {};
        stage_frame(dst_mac, src_mac, ethertype, vlan_en, vlan_tci);
        base = rx_q.size();
        run_frames(1, 0);
        compare_stream("d1", base);
        drv_q = {}; drv_last_q = {};
        foreach (pl_q[i]) begin
            drv_q.push_back(pl_q[i]);
            drv_last_q.push_back(i == pl_q.size() - 1);
        end
        base2 = rx_q.size();
        rand_rdy = 1'b1;
        run_frames(1, 30);
        rand_rdy = 1'b0;
        compare_stream("d2", base2);
        mism = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base2 + i >= rx_q.size() || rx_q[base2 + i] != rx_q[base + i]) mism++;
        end
        check_eq("d_identical", mism, 0);
        check_eq("d_stalls_seen", stall_seen > 0, 1'b1);

        // E: back-to-back frames, upstream always valid
        set_hdr(48'h020000000001, 48'h020000000002, 16'h0806, 1'b0, 16'h0);
        exp_q = {}; exp_last_q = {};
        rand_payload(20);
        stage_frame(dst_mac, src_mac, ethertype, vlan_en, vlan_tci);
        rand_payload(60);
        stage_frame(dst_mac, src_mac, ethertype, vlan_en, vlan_tci);
        base = rx_q.size(); gbase = gap_q.size(); db = done_cnt;
        run_frames(2, 0);
        compare_stream("e", base);
        check_eq("e_done_pulses", done_cnt - db, 2);
        if (gap_q.size() > gbase + 1) check_eq("e_ifg", gap_q[gbase + 1], 12);
        else check_eq("e_gap_seen", gap_q.size(), gbase + 2);

        // F: reset during SRC, then a clean frame
        rand_payload(30);
        exp_q = {}; exp_last_q = {};
        stage_frame(dst_mac, src_mac, ethertype, vlan_en, vlan_tci);
        fork
            drive_payload(0);
            begin
                for (int k = 0; k < 300 && frm_bytes < 16; k++) @(negedge clk);
                check_eq("f_reach_src", frm_bytes >= 16, 1'b1);
                #2;
                aresetn = 1'b0;
                abort   = 1'b1;
                #1;
                check_idle_outputs("f_rst");
            end
        join
        drv_q = {}; drv_last_q = {};
        repeat (3) @(posedge clk);
        #1;
        aresetn = 1'b1;
        abort   = 1'b0;
        set_hdr(48'h00AABBCCDDEE, 48'h001122334455, 16'h0800, 1'b0, 16'h0);
        rand_payload(50);
        exp_q = {}; exp_last_q = {};
        stage_frame(dst_mac, src_mac, ethertype, vlan_en, vlan_tci);
        base = rx_q.size();
        run_frames(1, 0);
        compare_stream("f", base);

        check_eq("done_without_tlast", done_bad, 0);
        check_eq("stall_unstable", stall_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
